// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, strobe levels, default widths, index-width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Memory strobes are active low.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam int DEF_NREQ = 2;
    localparam int DEF_AW   = 8;
    localparam int DEF_DW   = 8;

    // Bits needed to index n items; never less than one so 1-entry cases stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request bus from NREQ masters plus the shared memory port.
// Latency: n/a (wiring only).
// Backpressure: masters hold req until their one-cycle ack.
// Modports: slave = arbiter side, master = masters + memory model side.
// The lock vector exists only when MEM_ARB_LOCK_EN is defined.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               mem_R_n;
    logic               mem_W_n;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic [NREQ-1:0]    lock;

    modport slave (
        input  req, we, addr, wdata, mem_rdata, lock,
        output gnt, ack, rdata, mem_R_n, mem_W_n, mem_addr, mem_wdata
    );
    modport master (
        output req, we, addr, wdata, mem_rdata, lock,
        input  gnt, ack, rdata, mem_R_n, mem_W_n, mem_addr, mem_wdata
    );
`else
    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, ack, rdata, mem_R_n, mem_W_n, mem_addr, mem_wdata
    );
    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, ack, rdata, mem_R_n, mem_W_n, mem_addr, mem_wdata
    );
`endif
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: round-robin winner selection among NREQ request lines.
// Latency: combinational.
// Backpressure: none; gnt is all-zero when no request is pending.
// Ports: req (requests), last (previous winner) -> gnt (one-hot), idx (winner index).
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    // Scan last+1, last+2, ... with wrap; last itself is checked last.
    always_comb begin : scan
        int   pos;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = int'(last) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            if (!found && req[pos[IW-1:0]]) begin
                found                = 1'b1;
                gnt[pos[IW-1:0]]     = 1'b1;
                idx                  = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port among NREQ masters, round-robin, fixed-length strobes.
// Latency: req sampled in IDLE -> ack after ACCESS_CYCLES+1 cycles; one access per ACCESS_CYCLES+2.
// Backpressure: masters hold req until ack; requests are only sampled in IDLE.
// Ports: clk, rst (async, active high), bus (mem_arbiter_if.slave: masters + memory).
// Optional MEM_ARB_LOCK_EN: a master holding lock at the end of its access keeps the port next time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ          = DEF_NREQ,
    parameter int AW            = DEF_AW,
    parameter int DW            = DEF_DW,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = idx_w(ACCESS_CYCLES + 1);

    state_t          state, state_nxt;
    logic [NREQ-1:0] gnt_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            op_q;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   last;
    logic [NREQ-1:0] rr_gnt, win_gnt;
    logic [IW-1:0]   rr_idx, win_idx;
    logic            grant;
    logic            access_end;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (bus.req),
        .last (last),
        .gnt  (rr_gnt),
        .idx  (rr_idx)
    );

`ifdef MEM_ARB_LOCK_EN
    logic locked;
    logic lock_hold;

    // While locked, only the previous owner is eligible, and only if it still wants the port.
    assign lock_hold = locked && bus.req[last] && bus.lock[last];

    always_comb begin
        win_gnt = rr_gnt;
        win_idx = rr_idx;
        if (lock_hold) begin
            win_gnt = NREQ'(1) << last;
            win_idx = last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            locked <= 1'b0;
        else if (access_end)
            locked <= bus.lock[last];
        else if (state == ST_IDLE && !lock_hold)
            locked <= 1'b0;
    end
`else
    assign win_gnt = rr_gnt;
    assign win_idx = rr_idx;
`endif

    assign grant      = (state == ST_IDLE) && (|bus.req);
    assign access_end = (state == ST_ACCESS) && (cnt == CW'(ACCESS_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|bus.req)  state_nxt = ST_ACCESS;
            ST_ACCESS: if (access_end) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Reset to last = NREQ-1 so master 0 is first in line after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_q    <= 1'b0;
            cnt     <= '0;
            last    <= IW'(NREQ - 1);
        end else begin
            if (grant) begin
                gnt_q   <= win_gnt;
                addr_q  <= bus.addr[win_idx*AW +: AW];
                wdata_q <= bus.wdata[win_idx*DW +: DW];
                op_q    <= bus.we[win_idx];
                cnt     <= '0;
                last    <= win_idx;
            end
            if (state == ST_ACCESS) begin
                cnt <= cnt + 1'b1;
                if (access_end && !op_q)
                    rdata_q <= bus.mem_rdata;
            end
            if (state == ST_DONE)
                gnt_q <= '0;
        end
    end

    // Strobes and ack decode straight from state, so an async reset drops them at once.
    assign bus.gnt       = gnt_q;
    assign bus.ack       = (state == ST_DONE) ? gnt_q : '0;
    assign bus.rdata     = rdata_q;
    assign bus.mem_R_n   = (state == ST_ACCESS && !op_q) ? STROBE_ON : STROBE_OFF;
    assign bus.mem_W_n   = (state == ST_ACCESS &&  op_q) ? STROBE_ON : STROBE_OFF;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (2-master/1-cycle and 3-master/3-cycle builds).
// Latency: n/a.
// Backpressure: masters modelled as holding req until ack.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    mem_arbiter_if #(.NREQ(2), .AW(8), .DW(8)) bus_a ();
    mem_arbiter_if #(.NREQ(3), .AW(8), .DW(8)) bus_b ();

    mem_arbiter #(.NREQ(2), .AW(8), .DW(8), .ACCESS_CYCLES(1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    mem_arbiter #(.NREQ(3), .AW(8), .DW(8), .ACCESS_CYCLES(3)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] init_val(input int a);
        return (a == 5) ? 8'h3C : (8'(a) ^ 8'hA5);
    endfunction

    // Memory models: combinational read, write on the clock edge while W_n is low.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_val(i);
        end else if (bus_a.mem_W_n == 1'b0) begin
            mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_val(i);
        end else if (bus_b.mem_W_n == 1'b0) begin
            mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        end
    end
    assign bus_a.mem_rdata = mem_a[bus_a.mem_addr];
    assign bus_b.mem_rdata = mem_b[bus_b.mem_addr];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: previous winner, memory contents, last read data.
    int         last_a, last_b;
    logic [7:0] ref_mem_a [256];
    logic [7:0] rdata_ref_a, rdata_ref_b;

    task automatic ref_reset();
        last_a = 1;
        last_b = 2;
        for (int i = 0; i < 256; i++) ref_mem_a[i] = init_val(i);
        rdata_ref_a = 8'h00;
        rdata_ref_b = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One batch of simultaneous requests on the 2-master/1-cycle arbiter.
    task automatic run_round_a(input logic [1:0] mask, input logic [1:0] we,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
        int         order[$];
        logic [7:0] ad[2];
        logic [7:0] wd[2];
        logic [1:0] exp_strb;
        logic [1:0] oh;
        ad[0] = a0; ad[1] = a1; wd[0] = d0; wd[1] = d1;
        for (int k = 1; k <= 2; k++)
            if (mask[(last_a + k) % 2]) order.push_back((last_a + k) % 2);
        bus_a.req   = mask;
        bus_a.we    = we;
        bus_a.addr  = {a1, a0};
        bus_a.wdata = {d1, d0};
        foreach (order[j]) begin
            int m;
            m        = order[j];
            oh       = 2'(1 << m);
            exp_strb = we[m] ? 2'b10 : 2'b01;
            tick();
            n_cmp++; if (bus_a.gnt !== oh) begin n_err++; $display("FAIL a_gnt: got %b want %b", bus_a.gnt, oh); end
            n_cmp++; if ({bus_a.mem_R_n, bus_a.mem_W_n} !== exp_strb) begin n_err++; $display("FAIL a_strobe: got %b want %b", {bus_a.mem_R_n, bus_a.mem_W_n}, exp_strb); end
            n_cmp++; if (bus_a.mem_addr !== ad[m]) begin n_err++; $display("FAIL a_mem_addr: got %h want %h", bus_a.mem_addr, ad[m]); end
            if (we[m]) begin
                n_cmp++; if (bus_a.mem_wdata !== wd[m]) begin n_err++; $display("FAIL a_mem_wdata: got %h want %h", bus_a.mem_wdata, wd[m]); end
            end
            n_cmp++; if (bus_a.ack !== 2'b00) begin n_err++; $display("FAIL a_ack_early: got %b want 00", bus_a.ack); end
            tick();
            if (we[m]) ref_mem_a[ad[m]] = wd[m];
            else       rdata_ref_a = ref_mem_a[ad[m]];
            n_cmp++; if (bus_a.ack !== oh) begin n_err++; $display("FAIL a_ack: got %b want %b", bus_a.ack, oh); end
            n_cmp++; if (bus_a.gnt !== oh) begin n_err++; $display("FAIL a_gnt_done: got %b want %b", bus_a.gnt, oh); end
            n_cmp++; if (bus_a.rdata !== rdata_ref_a) begin n_err++; $display("FAIL a_rdata: got %h want %h", bus_a.rdata, rdata_ref_a); end
            n_cmp++; if ({bus_a.mem_R_n, bus_a.mem_W_n} !== 2'b11) begin n_err++; $display("FAIL a_strobe_done: got %b want 11", {bus_a.mem_R_n, bus_a.mem_W_n}); end
            bus_a.req[m] = 1'b0;
            tick();
            n_cmp++; if (bus_a.ack !== 2'b00) begin n_err++; $display("FAIL a_ack_width: got %b want 00", bus_a.ack); end
            last_a = m;
        end
    endtask

    // One batch of simultaneous reads on the 3-master/3-cycle arbiter.
    task automatic run_round_b(input logic [2:0] mask, input logic [23:0] addrs);
        int         order[$];
        logic [2:0] oh;
        logic [7:0] am;
        for (int k = 1; k <= 3; k++)
            if (mask[(last_b + k) % 3]) order.push_back((last_b + k) % 3);
        bus_b.req  = mask;
        bus_b.we   = 3'b000;
        bus_b.addr = addrs;
        foreach (order[j]) begin
            int m;
            m  = order[j];
            oh = 3'(1 << m);
            am = addrs[m*8 +: 8];
            for (int c = 0; c < 3; c++) begin
                tick();
                n_cmp++; if (bus_b.gnt !== oh) begin n_err++; $display("FAIL b_gnt: got %b want %b", bus_b.gnt, oh); end
                n_cmp++; if ({bus_b.mem_R_n, bus_b.mem_W_n} !== 2'b01) begin n_err++; $display("FAIL b_strobe cycle %0d: got %b want 01", c, {bus_b.mem_R_n, bus_b.mem_W_n}); end
                n_cmp++; if (bus_b.mem_addr !== am) begin n_err++; $display("FAIL b_mem_addr: got %h want %h", bus_b.mem_addr, am); end
                n_cmp++; if (bus_b.ack !== 3'b000) begin n_err++; $display("FAIL b_ack_early: got %b want 000", bus_b.ack); end
            end
            tick();
            rdata_ref_b = init_val(int'(am));
            n_cmp++; if (bus_b.ack !== oh) begin n_err++; $display("FAIL b_ack: got %b want %b", bus_b.ack, oh); end
            n_cmp++; if (bus_b.rdata !== rdata_ref_b) begin n_err++; $display("FAIL b_rdata: got %h want %h", bus_b.rdata, rdata_ref_b); end
            n_cmp++; if (bus_b.mem_R_n !== 1'b1) begin n_err++; $display("FAIL b_strobe_done: got %b want 1", bus_b.mem_R_n); end
            bus_b.req[m] = 1'b0;
            tick();
            n_cmp++; if (bus_b.ack !== 3'b000) begin n_err++; $display("FAIL b_ack_width: got %b want 000", bus_b.ack); end
            last_b = m;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.req = '0; bus_a.we = '0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = '0; bus_b.we = '0; bus_b.addr = '0; bus_b.wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        bus_a.lock = '0;
        bus_b.lock = '0;
`endif
        ref_reset();
        repeat (3) tick();
        n_cmp++; if (bus_a.gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", bus_a.gnt); end
        n_cmp++; if (bus_a.ack !== 2'b00) begin n_err++; $display("FAIL rst_ack: got %b want 00", bus_a.ack); end
        n_cmp++; if (bus_a.rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h want 00", bus_a.rdata); end
        n_cmp++; if ({bus_a.mem_R_n, bus_a.mem_W_n} !== 2'b11) begin n_err++; $display("FAIL rst_strobes: got %b want 11", {bus_a.mem_R_n, bus_a.mem_W_n}); end
        n_cmp++; if (bus_a.mem_addr !== 8'h00) begin n_err++; $display("FAIL rst_mem_addr: got %h want 00", bus_a.mem_addr); end
        n_cmp++; if (bus_a.mem_wdata !== 8'h00) begin n_err++; $display("FAIL rst_mem_wdata: got %h want 00", bus_a.mem_wdata); end
        n_cmp++; if (bus_b.gnt !== 3'b000) begin n_err++; $display("FAIL rst_b_gnt: got %b want 000", bus_b.gnt); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++; if (bus_a.gnt !== 2'b00) begin n_err++; $display("FAIL idle_gnt: got %b want 00", bus_a.gnt); end
    endtask

    task automatic test_single_read();
        run_round_a(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_write_readback();
        run_round_a(2'b10, 2'b10, 8'h00, 8'h10, 8'h00, 8'hA7);
        run_round_a(2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00);
    endtask

    task automatic test_contention();
        for (int r = 0; r < 3; r++)
            run_round_a(2'b11, 2'b00, 8'(r), 8'(r + 8), 8'h00, 8'h00);
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++)
            run_round_a(2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom_range(0, 15)),
                        8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_access_cycles();
        run_round_b(3'b001, {8'h00, 8'h00, 8'h05});
        run_round_b(3'b111, {8'($urandom), 8'($urandom), 8'($urandom)});
        run_round_b(3'b101, {8'h33, 8'h00, 8'h44});
    endtask

    task automatic test_mid_reset();
        bus_a.req = 2'b01; bus_a.we = 2'b00; bus_a.addr = {8'h00, 8'h20};
        tick();
        n_cmp++; if (bus_a.mem_R_n !== 1'b0) begin n_err++; $display("FAIL mr_pre_strobe: got %b want 0", bus_a.mem_R_n); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus_a.mem_R_n !== 1'b1) begin n_err++; $display("FAIL mr_strobe: got %b want 1", bus_a.mem_R_n); end
        n_cmp++; if (bus_a.gnt !== 2'b00) begin n_err++; $display("FAIL mr_gnt: got %b want 00", bus_a.gnt); end
        n_cmp++; if (bus_a.ack !== 2'b00) begin n_err++; $display("FAIL mr_ack: got %b want 00", bus_a.ack); end
        bus_a.req = 2'b00;
        ref_reset();
        tick();
        n_cmp++; if (bus_a.ack !== 2'b00) begin n_err++; $display("FAIL mr_ack_held: got %b want 00", bus_a.ack); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++; if (bus_a.ack !== 2'b00) begin n_err++; $display("FAIL mr_ack_after: got %b want 00", bus_a.ack); end
        n_cmp++; if (bus_a.rdata !== 8'h00) begin n_err++; $display("FAIL mr_rdata: got %h want 00", bus_a.rdata); end
        run_round_a(2'b11, 2'b00, 8'h05, 8'h06, 8'h00, 8'h00);
    endtask

    // Master 0 wants two accesses, master 1 one; master 0 may lock across its pair.
    task automatic test_lock();
        int         exp_order[3];
        int         left[2];
        logic [7:0] ad[2];
        logic [1:0] oh;
        run_round_a(2'b10, 2'b00, 8'h00, 8'h07, 8'h00, 8'h00);
`ifdef MEM_ARB_LOCK_EN
        exp_order  = '{0, 0, 1};
        bus_a.lock = 2'b01;
`else
        exp_order  = '{0, 1, 0};
`endif
        left[0] = 2; left[1] = 1;
        ad[0] = 8'h30; ad[1] = 8'h31;
        bus_a.req = 2'b11; bus_a.we = 2'b00; bus_a.addr = {ad[1], ad[0]};
        for (int k = 0; k < 3; k++) begin
            int m;
            m  = exp_order[k];
            oh = 2'(1 << m);
            tick();
            n_cmp++; if (bus_a.gnt !== oh) begin n_err++; $display("FAIL lock_gnt step %0d: got %b want %b", k, bus_a.gnt, oh); end
`ifdef MEM_ARB_LOCK_EN
            if (m == 0 && left[0] == 1) bus_a.lock = 2'b00;
`endif
            tick();
            rdata_ref_a = ref_mem_a[ad[m]];
            n_cmp++; if (bus_a.ack !== oh) begin n_err++; $display("FAIL lock_ack step %0d: got %b want %b", k, bus_a.ack, oh); end
            n_cmp++; if (bus_a.rdata !== rdata_ref_a) begin n_err++; $display("FAIL lock_rdata: got %h want %h", bus_a.rdata, rdata_ref_a); end
            left[m] = left[m] - 1;
            if (left[m] == 0) bus_a.req[m] = 1'b0;
            tick();
            n_cmp++; if (bus_a.ack !== 2'b00) begin n_err++; $display("FAIL lock_ack_width: got %b want 00", bus_a.ack); end
        end
        last_a = exp_order[2];
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_readback();
        test_contention();
        test_random();
        test_access_cycles();
        test_mid_reset();
        test_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8-bit memory port between NREQ bus masters, for example the CPU fetch/execute path and a program loader/DMA.
- Each master posts a request and holds it until a one-cycle ack. The arbiter picks the winner round-robin and drives the active-low R/W strobes for a fixed number of cycles.
- The arbiter captures read data and returns it with the ack. It sits between the masters and the memory model/RAM.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 8, address width.
- DW, 8, data width.
- ACCESS_CYCLES, 1, cycles the strobe is held low per access (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-master request; held until ack.
- we  in  NREQ  per-master: 1 = write, 0 = read; stable while req is high.
- addr  in  NREQ*AW  flattened addresses; master i uses bits [i*AW +: AW].
- wdata  in  NREQ*DW  flattened write data, same packing as addr.
- gnt  out  NREQ  one-hot owner of the current access.
- ack  out  NREQ  one-cycle completion pulse to the owner.
- rdata  out  DW  read data; valid while ack is high.
- mem_R_n  out  1  memory read strobe, active low.
- mem_W_n  out  1  memory write strobe, active low.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; combinational, valid in the same cycle mem_R_n is low.

Behaviour:
- Reset values: state IDLE, gnt=0, ack=0, rdata=0, mem_R_n=1, mem_W_n=1, mem_addr=0, mem_wdata=0, cnt=0, last=NREQ-1 (so master 0 wins first).
- Asserting rst mid-access aborts immediately: both strobes go high and no ack is issued.
- IDLE state:
  - If any req is high, pick winner w: the first requester with req high, scanning from (last+1) mod NREQ upward with wrap.
  - On the same edge: register gnt=onehot(w), mem_addr=addr[w], mem_wdata=wdata[w], op=we[w], cnt=0, last=w; go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS state:
  - Read (op=0): mem_R_n=0. Write (op=1): mem_W_n=0. The strobes are decoded from state and op, so the strobe is low exactly while in ACCESS.
  - mem_addr and mem_wdata are stable for the whole state.
  - cnt increments each cycle. On the edge where cnt==ACCESS_CYCLES-1: reads capture rdata<=mem_rdata; go to DONE.
- DONE state:
  - ack[w]=1 for exactly one cycle; gnt is held; strobes are high; then return to IDLE.
  - rdata holds its value until the next read completes. Writes leave rdata unchanged.
- Master rule: deassert req on the edge where ack is sampled high. A req still high in the IDLE cycle after DONE is treated as a new request.
- Latency: req seen in IDLE to ack = ACCESS_CYCLES+1 cycles. Throughput: one access per ACCESS_CYCLES+2 cycles.
- Masters never see both strobes low; this is asserted in the bench.
- Requests arriving or dropping during ACCESS/DONE are ignored until IDLE.
- Dropping req before ack is illegal; the access still completes and acks.
- Round-robin fairness: with all NREQ requesting continuously, each master is granted exactly once per NREQ accesses.
- Out-of-range masters do not exist: only bits below NREQ are scanned.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- With the macro defined:
  - Extra input port lock [NREQ]. If lock[w] is high on the edge into DONE, the arbiter sets a locked flag.
  - In the following IDLE, only master w is eligible and last is not advanced. This allows atomic read-modify-write.
  - The flag clears when w enters IDLE with lock[w] low, or when req[w] is low in IDLE.
  - Reset clears the flag.
- Without the macro: no lock port; pure round-robin.

Decomposition:
- Package mem_arb_pkg:
  - state encoding ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2;
  - STROBE_ON=1'b0, STROBE_OFF=1'b1;
  - default AW/DW constants.
- Sub-module rr_pick: combinational; inputs req[NREQ], last; outputs one-hot gnt and index. It is instantiated once and unit-tested separately.

Test Plan:
- Reset then single read: memory[0x05]=0x3C; master0 req, we=0, addr=0x05. Expect mem_R_n low for 1 cycle with mem_addr=0x05, ack[0] 2 cycles after req, rdata=0x3C, mem_W_n high throughout.
- Write then read-back: master1 writes 0xA7 to 0x10, then reads 0x10. Expect mem_W_n low 1 cycle with mem_wdata=0xA7, then rdata=0xA7; ack[1] pulses twice; ack[0] stays 0.
- Contention: both masters request continuously for 6 accesses. Expect grant order 0,1,0,1,0,1, each ack exactly 1 cycle wide, one access every 3 cycles.
- ACCESS_CYCLES=3 instance: a read holds mem_R_n low for exactly 3 cycles with a stable address; ack arrives 4 cycles after req.
- Reset mid-access: assert rst while mem_R_n=0. Expect mem_R_n=1 immediately (async), gnt=0, no ack; after release, master0 wins first.
- With MEM_ARB_LOCK_EN: master0 holds lock across 2 accesses while master1 requests. Expect order 0,0,1; without the macro, expect 0,1,0.
